// File: rtl/dac_pattern_pkg.sv
// Shared definitions for the DAC test-pattern generator: mode codes,
// PRBS23 polynomial constants and the power-on contents of the pattern table.
package dac_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_TABLE = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_PRBS  = 2'd2,
        MODE_ZERO  = 2'd3
    } mode_e;

    // x^23 + x^18 + 1, shifting towards the MSB with feedback into bit 0
    localparam int PRBS_LEN   = 23;
    localparam int PRBS_TAP_A = 22;
    localparam int PRBS_TAP_B = 17;
    localparam logic [PRBS_LEN-1:0] PRBS_SEED = '1;

    // I column of the reset table: +max, 0, -max repeating; the Q column is all zero.
    function automatic logic [15:0] reset_table_i(input int unsigned width, input int unsigned k);
        logic [15:0] half;
        half = 16'd1 << (width - 1);
        case (k % 3)
            0:       return half - 16'd1;
            1:       return 16'd0;
            default: return half;
        endcase
    endfunction

endpackage

// File: rtl/dac_pattern_prbs.sv
// PRBS23 source for the DAC pattern generator; steps once per advance,
// returns to the all-ones seed on clear. Presents the low DATA_WIDTH bits.
module dac_pattern_prbs
    import dac_pattern_pkg::*;
#(
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [PRBS_LEN-1:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= PRBS_SEED;
        end else if (clear) begin
            lfsr <= PRBS_SEED;
        end else if (advance) begin
            lfsr <= {lfsr[PRBS_LEN-2:0], lfsr[PRBS_TAP_A] ^ lfsr[PRBS_TAP_B]};
        end
    end

    assign dout = lfsr[DATA_WIDTH-1:0];

endmodule

// File: rtl/dac_pattern_gen.sv
// DAC-side test-pattern source (table / ramp / PRBS / zero) at a programmable beat cadence.
// PRBS mode is built only when DAC_PATTERN_GEN_PRBS_EN is defined; otherwise mode 2 outputs zeros.
module dac_pattern_gen
    import dac_pattern_pkg::*;
#(
    parameter int DATA_WIDTH    = 12,
    parameter int NUM_CHANNELS  = 1,
    parameter int PATTERN_DEPTH = 3,
    parameter int VALID_RATIO   = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [1:0]                         mode,
    input  logic                               tbl_wr,
    input  logic [3:0]                         tbl_addr,
    input  logic [DATA_WIDTH-1:0]              tbl_wdata_i,
    input  logic [DATA_WIDTH-1:0]              tbl_wdata_q,
    output logic                               dac_valid,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] dac_data_i,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] dac_data_q,
    output logic                               dac_r1_mode,
    output logic                               pattern_wrap
);

    localparam int CNT_W = (VALID_RATIO > 1) ? $clog2(VALID_RATIO) : 1;
    localparam int IDX_W = $clog2(PATTERN_DEPTH);

    logic [CNT_W-1:0]                  cnt;
    logic [IDX_W-1:0]                  idx;
    logic [DATA_WIDTH-1:0]             ramp;
    mode_e                             active_mode;
    logic [DATA_WIDTH-1:0]             tbl_i [PATTERN_DEPTH];
    logic [DATA_WIDTH-1:0]             tbl_q [PATTERN_DEPTH];
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] nxt_i, nxt_q;
    logic                              beat, last_idx, mode_load;

    assign dac_r1_mode = (NUM_CHANNELS == 1);
    assign beat        = enable && (cnt == '0);
    assign last_idx    = (idx == IDX_W'(PATTERN_DEPTH - 1));
    assign mode_load   = !enable || (beat && last_idx);

`ifdef DAC_PATTERN_GEN_PRBS_EN
    logic [DATA_WIDTH-1:0] prbs_data;

    dac_pattern_prbs #(.DATA_WIDTH(DATA_WIDTH)) u_prbs (
        .clk     (clk),
        .rst     (rst),
        .advance (beat && active_mode == MODE_PRBS),
        .clear   (!enable),
        .dout    (prbs_data)
    );
`endif

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [IDX_W:0]        sum;
        logic [IDX_W-1:0]      entry;
        logic [DATA_WIDTH-1:0] ramp_c, ch_i, ch_q;
`ifdef DAC_PATTERN_GEN_PRBS_EN
        localparam int ROT = (4 * c) % DATA_WIDTH;
        logic [DATA_WIDTH-1:0] prbs_c;
        assign prbs_c = (ROT == 0) ? prbs_data
                                   : ((prbs_data << ROT) | (prbs_data >> (DATA_WIDTH - ROT)));
`endif

        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        always_comb begin
            ch_i   = '0;
            ch_q   = '0;
            sum    = {1'b0, idx} + (IDX_W + 1)'(c);
            entry  = (sum >= (IDX_W + 1)'(PATTERN_DEPTH)) ? IDX_W'(sum - (IDX_W + 1)'(PATTERN_DEPTH))
                                                          : IDX_W'(sum);
            ramp_c = ramp + DATA_WIDTH'(c);
            case (active_mode)
                MODE_TABLE: begin
                    ch_i = tbl_i[entry];
                    ch_q = tbl_q[entry];
                end
                MODE_RAMP: begin
                    ch_i = ramp_c;
                    ch_q = ~ramp_c;
                end
`ifdef DAC_PATTERN_GEN_PRBS_EN
                MODE_PRBS: begin
                    ch_i = prbs_c;
                    ch_q = ~prbs_c;
                end
`endif
                default: ;
            endcase
        end

        assign nxt_i[c*DATA_WIDTH +: DATA_WIDTH] = ch_i;
        assign nxt_q[c*DATA_WIDTH +: DATA_WIDTH] = ch_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= '0;
            ramp         <= '0;
            active_mode  <= MODE_TABLE;
            dac_valid    <= 1'b0;
            pattern_wrap <= 1'b0;
            dac_data_i   <= '0;
            dac_data_q   <= '0;
        end else begin
            dac_valid    <= beat;
            pattern_wrap <= beat && last_idx;
            if (!enable) begin
                cnt  <= '0;
                idx  <= '0;
                ramp <= '0;
            end else begin
                cnt <= (cnt == CNT_W'(VALID_RATIO - 1)) ? '0 : cnt + CNT_W'(1);
                if (beat) begin
                    dac_data_i <= nxt_i;
                    dac_data_q <= nxt_q;
                    idx        <= last_idx ? '0 : idx + IDX_W'(1);
                    if (active_mode == MODE_RAMP) begin
                        ramp <= ramp + DATA_WIDTH'(1);
                    end
                end
            end
            if (mode_load) begin
                active_mode <= mode_e'(mode);
            end
        end
    end

    // NOTE: the table is a reset flop array, not RAM, because reset must restore its contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PATTERN_DEPTH; k++) begin
                tbl_i[k] <= DATA_WIDTH'(reset_table_i(DATA_WIDTH, k));
                tbl_q[k] <= '0;
            end
        end else if (tbl_wr && (int'(tbl_addr) < PATTERN_DEPTH)) begin
            tbl_i[tbl_addr[IDX_W-1:0]] <= tbl_wdata_i;
            tbl_q[tbl_addr[IDX_W-1:0]] <= tbl_wdata_q;
        end
    end

endmodule

// File: tb/tb_dac_pattern_gen.sv
// Scoreboard bench for dac_pattern_gen: two instances (default, and 2-channel valid-every-cycle)
// share stimulus; a beat-level reference model pushes expected beats, negedge monitors pop and compare.
module tb_dac_pattern_gen;

    localparam int DW      = 12;
    localparam int DEPTH   = 3;
    localparam int VR0     = 2;
    localparam int NC0     = 1;
    localparam int VR1     = 1;
    localparam int NC1     = 2;
    localparam int SEQ_LEN = 40000;

    logic clk = 1'b0;
    logic rst, enable, tbl_wr;
    logic [1:0]    mode;
    logic [3:0]    tbl_addr;
    logic [DW-1:0] wdi, wdq;

    logic v0, v1, r1m0, r1m1, w0, w1;
    logic [NC0*DW-1:0] di0, dq0;
    logic [NC1*DW-1:0] di1, dq1;

    always #5 clk = ~clk;

    dac_pattern_gen #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC0), .PATTERN_DEPTH(DEPTH), .VALID_RATIO(VR0)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .tbl_wr(tbl_wr), .tbl_addr(tbl_addr),
        .tbl_wdata_i(wdi), .tbl_wdata_q(wdq), .dac_valid(v0), .dac_data_i(di0), .dac_data_q(dq0),
        .dac_r1_mode(r1m0), .pattern_wrap(w0));

    dac_pattern_gen #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC1), .PATTERN_DEPTH(DEPTH), .VALID_RATIO(VR1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .tbl_wr(tbl_wr), .tbl_addr(tbl_addr),
        .tbl_wdata_i(wdi), .tbl_wdata_q(wdq), .dac_valid(v1), .dac_data_i(di1), .dac_data_q(dq1),
        .dac_r1_mode(r1m1), .pattern_wrap(w1));

    typedef struct {
        logic [31:0] i;
        logic [31:0] q;
        logic        wrap;
    } beat_t;

    beat_t sb0[$];
    beat_t sb1[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (beat level) ----------------
    bit            prbs_seq [SEQ_LEN];
    int            run   [2];
    int            beats [2];
    int            rampc [2];
    int            ppos  [2];
    logic [1:0]    act   [2];
    logic [DW-1:0] mti   [2][DEPTH];
    logic [DW-1:0] mtq   [2][DEPTH];

    // b[0..22] is the all-ones seed; b[k] = b[k-23] ^ b[k-18]; after p steps output bit j = b[22+p-j]
    initial begin
        for (int k = 0; k < 23; k++) prbs_seq[k] = 1'b1;
        for (int k = 23; k < SEQ_LEN; k++) prbs_seq[k] = prbs_seq[k-23] ^ prbs_seq[k-18];
    end

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            run[n] = 0; beats[n] = 0; rampc[n] = 0; ppos[n] = 0; act[n] = 2'd0;
            for (int k = 0; k < DEPTH; k++) begin
                mti[n][k] = (k % 3 == 0) ? 12'h7FF : (k % 3 == 1) ? 12'h000 : 12'h800;
                mtq[n][k] = 12'h000;
            end
        end
        sb0.delete();
        sb1.delete();
    endtask

    task automatic sample(input int n, input int c, input int idx, output logic [DW-1:0] si,
                          output logic [DW-1:0] sq);
        si = '0;
        sq = '0;
        case (act[n])
            2'd0: begin
                si = mti[n][(idx + c) % DEPTH];
                sq = mtq[n][(idx + c) % DEPTH];
            end
            2'd1: begin
                si = DW'((rampc[n] + c) % 4096);
                sq = ~si;
            end
`ifdef DAC_PATTERN_GEN_PRBS_EN
            2'd2: begin
                if (ppos[n] + 23 >= SEQ_LEN) begin
                    checks++; errors++;
                    $display("FAIL prbs_model_range position=%0d limit=%0d", ppos[n], SEQ_LEN - 23);
                end else begin
                    for (int j = 0; j < DW; j++) si[(j + 4 * c) % DW] = prbs_seq[22 + ppos[n] - j];
                end
                sq = ~si;
            end
`endif
            default: ;
        endcase
    endtask

    task automatic model_step(input int n, input int vr, input int nc);
        beat_t         b;
        int            idx;
        logic [DW-1:0] si, sq;
        if (!enable) begin
            run[n] = 0; beats[n] = 0; rampc[n] = 0; ppos[n] = 0; act[n] = mode;
        end else begin
            if (run[n] % vr == 0) begin
                idx    = beats[n] % DEPTH;
                b.i    = '0;
                b.q    = '0;
                b.wrap = (idx == DEPTH - 1);
                for (int c = 0; c < nc; c++) begin
                    sample(n, c, idx, si, sq);
                    b.i |= 32'(si) << (c * DW);
                    b.q |= 32'(sq) << (c * DW);
                end
                if (n == 0) sb0.push_back(b);
                else        sb1.push_back(b);
                beats[n]++;
                if (act[n] == 2'd1) rampc[n]++;
                if (act[n] == 2'd2) ppos[n]++;
                if (b.wrap) act[n] = mode;
            end
            run[n]++;
        end
        if (tbl_wr && tbl_addr < DEPTH) begin
            mti[n][tbl_addr] = wdi;
            mtq[n][tbl_addr] = wdq;
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            model_step(0, VR0, NC0);
            model_step(1, VR1, NC1);
        end
    end

    // ---------------- monitors ----------------
    logic [31:0] exp_i0 = '0, exp_q0 = '0, exp_i1 = '0, exp_q1 = '0;

    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            check("rst_valid0", 32'(v0), 32'd0);
            check("rst_data_i0", 32'(di0), 32'd0);
            check("rst_wrap0", 32'(w0), 32'd0);
            exp_i0 = '0; exp_q0 = '0;
        end else if (v0) begin
            if (sb0.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat0_unexpected actual=valid expected=idle at %0t", $time);
            end else begin
                b = sb0.pop_front();
                exp_i0 = b.i; exp_q0 = b.q;
                check("beat_i0", 32'(di0), exp_i0);
                check("beat_q0", 32'(dq0), exp_q0);
                check("beat_wrap0", 32'(w0), 32'(b.wrap));
            end
        end else begin
            check("hold_i0", 32'(di0), exp_i0);
            check("hold_q0", 32'(dq0), exp_q0);
            check("idle_wrap0", 32'(w0), 32'd0);
        end
    end

    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            check("rst_valid1", 32'(v1), 32'd0);
            check("rst_data_q1", 32'(dq1), 32'd0);
            check("rst_wrap1", 32'(w1), 32'd0);
            exp_i1 = '0; exp_q1 = '0;
        end else if (v1) begin
            if (sb1.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat1_unexpected actual=valid expected=idle at %0t", $time);
            end else begin
                b = sb1.pop_front();
                exp_i1 = b.i; exp_q1 = b.q;
                check("beat_i1", 32'(di1), exp_i1);
                check("beat_q1", 32'(dq1), exp_q1);
                check("beat_wrap1", 32'(w1), 32'(b.wrap));
            end
        end else begin
            check("hold_i1", 32'(di1), exp_i1);
            check("hold_q1", 32'(dq1), exp_q1);
            check("idle_wrap1", 32'(w1), 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_tbl(input logic [3:0] a, input logic [DW-1:0] i, input logic [DW-1:0] q);
        tbl_wr = 1'b1; tbl_addr = a; wdi = i; wdq = q;
        cycles(1);
        tbl_wr = 1'b0;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_valid0", 32'(v0), 32'd0);
        check("async_rst_valid1", 32'(v1), 32'd0);
        check("async_rst_data_i1", 32'(di1), 32'd0);
        cycles(3);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 2'd0; tbl_wr = 1'b0; tbl_addr = '0; wdi = '0; wdq = '0;
        model_reset();
        cycles(3);
        check("r1_mode_single", 32'(r1m0), 32'd1);
        check("r1_mode_dual", 32'(r1m1), 32'd0);
        rst = 1'b0;
        cycles(2);

        // table mode from reset contents
        enable = 1'b1;
        cycles(25);

        // live table writes, including an out-of-range address
        write_tbl(4'd1, 12'h123, 12'h456);
        write_tbl(4'd5, 12'hABC, 12'hDEF);
        cycles(20);

        // ramp requested mid-pattern, long enough to wrap the 12-bit ramp on both instances
        cycles(1);
        mode = 2'd1;
        cycles(8400);

        // PRBS (zero mode when the PRBS macro is absent)
        mode = 2'd2;
        cycles(2100);

        // randomized run/stop, mode and table traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            tbl_wr   = ($urandom_range(0, 3) == 0);
            tbl_addr = 4'($urandom_range(0, 15));
            wdi      = DW'($urandom);
            wdq      = DW'($urandom);
            cycles(1);
        end
        tbl_wr = 1'b0;

        // pause, restart, then reset mid-pattern; table must come back to its reset contents
        mode = 2'd0;
        enable = 1'b0;
        cycles(3);
        enable = 1'b1;
        cycles(4);
        async_reset();
        cycles(20);

        enable = 1'b0;
        cycles(4);
        check("sb0_drained", 32'(sb0.size()), 32'd0);
        check("sb1_drained", 32'(sb1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
